// File: rtl/jk_reg_bank_pkg.sv
// rtl/jk_reg_bank_pkg.sv - shared types and the per-bit JK next-state function
//
// Purpose : mode enum and the pure next-state function used by every JK cell.
// Contents: jk_mode_e (JK_SET_PRIO / JK_TOGGLE), jk_next(q, j, k, mode).
package jk_reg_bank_pkg;

  typedef enum logic {
    JK_SET_PRIO = 1'b0,  // J&K -> 1 (legacy set-priority cell)
    JK_TOGGLE   = 1'b1   // J&K -> ~Q
  } jk_mode_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k,
                                   input jk_mode_e mode);
    logic nxt;
    nxt = q;
    if (j && k)      nxt = (mode == JK_TOGGLE) ? ~q : 1'b1;
    else if (j)      nxt = 1'b1;
    else if (k)      nxt = 1'b0;
    return nxt;
  endfunction

endpackage

// File: rtl/jk_reg_bank_if.sv
// rtl/jk_reg_bank_if.sv - control/status bundle of the JK register bank
//
// Purpose : groups the request and status signals of jk_reg_bank.
// Ports   : master drives en, load, load_data, J, K, clear_count;
//           slave (the bank) drives Q, Q_n, rise, fall, any_change, change_count.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             clear_count;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_change;
  logic [CNT_W-1:0] change_count;

  modport master (
    output en, load, load_data, J, K, clear_count,
    input  Q, Q_n, rise, fall, any_change, change_count
  );

  modport slave (
    input  en, load, load_data, J, K, clear_count,
    output Q, Q_n, rise, fall, any_change, change_count
  );

endinterface

// File: rtl/jk_reg_bank_cell.sv
// rtl/jk_reg_bank_cell.sv - one JK flip-flop with load, enable and edge pulses
//
// Purpose : single JK channel; priority reset > load > (en ? JK rule : hold).
// Ports   : clk, reset (async, active-high), en, load, d (load value), j, k
//           in; q (state), rise/fall (registered 1-cycle edge pulses),
//           chg (combinational: this bit changes on the coming edge) out.
module jk_reg_bank_cell
  import jk_reg_bank_pkg::*;
#(
  parameter jk_mode_e MODE      = JK_TOGGLE,
  parameter logic     RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic load,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q,
  output logic rise,
  output logic fall,
  output logic chg
);

  logic q_next;

  always_comb begin
    q_next = q;
    if (load)    q_next = d;
    else if (en) q_next = jk_next(q, j, k, MODE);
  end

  assign chg = q_next ^ q;

  // Pulses are computed from the same q_next that updates q, so they line up
  // with the new state and vanish on the next edge unless q moves again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RESET_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q    <= q_next;
      rise <= ~q & q_next;
      fall <= q & ~q_next;
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// rtl/jk_reg_bank.sv - WIDTH-channel JK flag register with pulses and change counter
//
// Purpose : bank of independent JK cells sharing en/load, plus an any_change
//           pulse and a saturating count of edges on which any bit changed.
// Ports   : clk, reset (async, active-high);
//           bus (slave): en, load, load_data, J, K, clear_count in;
//           Q, Q_n (~Q), rise, fall, any_change, change_count out.
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter jk_mode_e         JK_MODE   = JK_TOGGLE,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input logic         clk,
  input logic         reset,
  jk_reg_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] chg;
  logic             any_change_next;
  logic             any_change_q;
  logic [CNT_W-1:0] count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_reg_bank_cell #(
      .MODE      (JK_MODE),
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .en   (bus.en),
      .load (bus.load),
      .d    (bus.load_data[i]),
      .j    (bus.J[i]),
      .k    (bus.K[i]),
      .q    (q[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i]),
      .chg  (chg[i])
    );
  end

  assign any_change_next = |chg;

  // clear_count wins over an increment on the same edge; the count sticks at
  // all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_change_q <= 1'b0;
      count_q      <= '0;
    end else begin
      any_change_q <= any_change_next;
      if (bus.clear_count)
        count_q <= '0;
      else if (any_change_next && (count_q != CNT_MAX))
        count_q <= count_q + CNT_ONE;
    end
  end

  assign bus.Q            = q;
  assign bus.Q_n          = ~q;
  assign bus.rise         = rise_w;
  assign bus.fall         = fall_w;
  assign bus.any_change   = any_change_q;
  assign bus.change_count = count_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb/tb_jk_reg_bank.sv - directed self-checking bench for jk_reg_bank
module tb_jk_reg_bank;
  import jk_reg_bank_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: toggle, RESET_VAL=A5 ; b: set-priority, reset 00 ; c: toggle, CNT_W=2
  jk_reg_bank_if #(.WIDTH(8), .CNT_W(8)) if_a ();
  jk_reg_bank_if #(.WIDTH(8), .CNT_W(8)) if_b ();
  jk_reg_bank_if #(.WIDTH(8), .CNT_W(2)) if_c ();

  jk_reg_bank #(.WIDTH(8), .JK_MODE(JK_TOGGLE), .RESET_VAL(8'hA5), .CNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  jk_reg_bank #(.WIDTH(8), .JK_MODE(JK_SET_PRIO), .RESET_VAL(8'h00), .CNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  jk_reg_bank #(.WIDTH(8), .JK_MODE(JK_TOGGLE), .RESET_VAL(8'h00), .CNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  // observed vectors: {Q, rise, fall, any_change, change_count}
  wire [32:0] obs_a = {if_a.Q, if_a.rise, if_a.fall, if_a.any_change, if_a.change_count};
  wire [32:0] obs_b = {if_b.Q, if_b.rise, if_b.fall, if_b.any_change, if_b.change_count};
  wire [26:0] obs_c = {if_c.Q, if_c.rise, if_c.fall, if_c.any_change, if_c.change_count};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_a.en = 0; if_a.load = 0; if_a.load_data = 0; if_a.J = 0; if_a.K = 0; if_a.clear_count = 0;
    if_b.en = 0; if_b.load = 0; if_b.load_data = 0; if_b.J = 0; if_b.K = 0; if_b.clear_count = 0;
    if_c.en = 0; if_c.load = 0; if_c.load_data = 0; if_c.J = 0; if_c.K = 0; if_c.clear_count = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (obs_a !== {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0});
    end
    checks++;
    if (if_a.Q_n !== 8'h5A) begin
      errors++; $display("FAIL reset_qn got=%h exp=5a", if_a.Q_n);
    end
    checks++;
    if (obs_b !== 33'd0) begin
      errors++; $display("FAIL reset_b got=%h exp=0", obs_b);
    end
    checks++;
    if (obs_c !== 27'd0) begin
      errors++; $display("FAIL reset_c got=%h exp=0", obs_c);
    end
    reset = 1'b0;
  endtask

  task automatic test_set();
    if_b.en = 1; if_b.J = 8'h0F; if_b.K = 8'h00;
    step();
    checks++;
    if (obs_b !== {8'h0F, 8'h0F, 8'h00, 1'b1, 8'd1}) begin
      errors++; $display("FAIL set_edge got=%h exp=%h", obs_b, {8'h0F, 8'h0F, 8'h00, 1'b1, 8'd1});
    end
    if_b.J = 8'h00;
    step();
    checks++;
    if (obs_b !== {8'h0F, 8'h00, 8'h00, 1'b0, 8'd1}) begin
      errors++; $display("FAIL set_hold got=%h exp=%h", obs_b, {8'h0F, 8'h00, 8'h00, 1'b0, 8'd1});
    end
  endtask

  task automatic test_set_prio();
    if_b.J = 8'hFF; if_b.K = 8'hFF;
    step();
    checks++;
    if (obs_b !== {8'hFF, 8'hF0, 8'h00, 1'b1, 8'd2}) begin
      errors++; $display("FAIL set_prio got=%h exp=%h", obs_b, {8'hFF, 8'hF0, 8'h00, 1'b1, 8'd2});
    end
    if_b.en = 0; if_b.J = 0; if_b.K = 0;
  endtask

  task automatic test_toggle();
    if_a.load = 1; if_a.load_data = 8'h0F;
    step();
    checks++;
    if (obs_a !== {8'h0F, 8'h0A, 8'hA0, 1'b1, 8'd1}) begin
      errors++; $display("FAIL load_0f got=%h exp=%h", obs_a, {8'h0F, 8'h0A, 8'hA0, 1'b1, 8'd1});
    end
    if_a.load = 0; if_a.en = 1; if_a.J = 8'hFF; if_a.K = 8'hFF;
    step();
    checks++;
    if (obs_a !== {8'hF0, 8'hF0, 8'h0F, 1'b1, 8'd2}) begin
      errors++; $display("FAIL toggle got=%h exp=%h", obs_a, {8'hF0, 8'hF0, 8'h0F, 1'b1, 8'd2});
    end
  endtask

  task automatic test_load_priority();
    if_a.load = 1; if_a.load_data = 8'h3C; if_a.en = 1; if_a.J = 8'hFF; if_a.K = 8'h00;
    step();
    checks++;
    if (obs_a !== {8'h3C, 8'h0C, 8'hC0, 1'b1, 8'd3}) begin
      errors++; $display("FAIL load_wins got=%h exp=%h", obs_a, {8'h3C, 8'h0C, 8'hC0, 1'b1, 8'd3});
    end
    step();
    checks++;
    if (obs_a !== {8'h3C, 8'h00, 8'h00, 1'b0, 8'd3}) begin
      errors++; $display("FAIL load_same got=%h exp=%h", obs_a, {8'h3C, 8'h00, 8'h00, 1'b0, 8'd3});
    end
  endtask

  task automatic test_hold();
    if_a.load = 0; if_a.en = 0; if_a.J = 8'hFF; if_a.K = 8'h00;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if (obs_a !== {8'h3C, 8'h00, 8'h00, 1'b0, 8'd3}) begin
        errors++; $display("FAIL hold_%0d got=%h exp=%h", n, obs_a, {8'h3C, 8'h00, 8'h00, 1'b0, 8'd3});
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    if_c.en = 1; if_c.J = 8'h01; if_c.K = 8'h01;
    for (int n = 0; n < 5; n++) begin
      step();
      checks++;
      if ({if_c.Q, if_c.any_change, if_c.change_count} !== {7'd0, ~n[0], 1'b1, exp_cnt[n]}) begin
        errors++; $display("FAIL sat_%0d got=%h exp=%h", n, {if_c.Q, if_c.any_change, if_c.change_count},
                           {7'd0, ~n[0], 1'b1, exp_cnt[n]});
      end
    end
    if_c.clear_count = 1;
    step();
    checks++;
    if (obs_c !== {8'h00, 8'h00, 8'h01, 1'b1, 2'd0}) begin
      errors++; $display("FAIL clear_beats_inc got=%h exp=%h", obs_c, {8'h00, 8'h00, 8'h01, 1'b1, 2'd0});
    end
    if_c.clear_count = 0; if_c.en = 0;
    step();
    checks++;
    if (obs_c !== 27'd0) begin
      errors++; $display("FAIL clear_after got=%h exp=0", obs_c);
    end
  endtask

  task automatic test_reset_mid();
    if_a.en = 1; if_a.J = 8'hFF; if_a.K = 8'h00;
    step();
    checks++;
    if (obs_a !== {8'hFF, 8'hC3, 8'h00, 1'b1, 8'd4}) begin
      errors++; $display("FAIL pre_reset got=%h exp=%h", obs_a, {8'hFF, 8'hC3, 8'h00, 1'b1, 8'd4});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs_a !== {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0}) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", obs_a, {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0});
    end
    checks++;
    if (if_b.change_count !== 8'd0) begin
      errors++; $display("FAIL async_reset_b got=%h exp=0", if_b.change_count);
    end
    step();
    checks++;
    if (obs_a !== {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", obs_a, {8'hA5, 8'h00, 8'h00, 1'b0, 8'd0});
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs_a !== {8'hFF, 8'h5A, 8'h00, 1'b1, 8'd1}) begin
      errors++; $display("FAIL first_after_reset got=%h exp=%h", obs_a, {8'hFF, 8'h5A, 8'h00, 1'b1, 8'd1});
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_set();
    test_set_prio();
    test_toggle();
    test_load_priority();
    test_hold();
    test_saturate();
    test_reset_mid();
    idle_all();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
